// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: one-at-a-time sequencer in front of a fixed-latency multi-cycle FPU.
// Accepts an op, resolves the rounding mode, holds operands at the FPU for the op's latency,
// captures the result and offers it on a valid/ready response port.
module fpu_issue_ctrl #(
    parameter int unsigned LAT_ADD  = 3,
    parameter int unsigned LAT_MUL  = 4,
    parameter int unsigned LAT_SQRT = 12,
    parameter int unsigned LAT_DIV  = 12,
    parameter int unsigned LAT_MISC = 1
) (
    input  logic        g_clk,
    input  logic        g_rst,
    input  logic        flush,
    // request port
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [2:0]  req_rm,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [31:0] req_c,
    input  logic [4:0]  req_rd,
    input  logic [2:0]  sys_rm,
    // FPU side
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic [31:0] fpu_c,
    output logic [4:0]  fpu_sel,
    output logic [2:0]  fpu_rm,
    output logic        fpu_enable,
    input  logic [31:0] fpu_res,
    // response port
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_rd,
    output logic        rsp_illegal,
    output logic        stall
);

    localparam int unsigned LAT_M01 = (LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL;
    localparam int unsigned LAT_M23 = (LAT_SQRT > LAT_DIV) ? LAT_SQRT : LAT_DIV;
    localparam int unsigned LAT_M03 = (LAT_M01 > LAT_M23) ? LAT_M01 : LAT_M23;
    localparam int unsigned LAT_MAX = (LAT_M03 > LAT_MISC) ? LAT_M03 : LAT_MISC;
    localparam int unsigned CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // Low for the cycle right after a reset edge so req_ready stays 0 until reset is released.
    logic               ready_en_q;

    logic [31:0]        a_q, b_q, c_q;
    logic [4:0]         sel_q;
    logic [2:0]         rm_q;
    logic [31:0]        data_q;
    logic [4:0]         rd_q;
    logic               ill_q;

    logic [2:0]         rm_res;
    logic               rm_illegal;
    logic               accept;

    // Remaining EXEC cycles after the first one, per op code.
    function automatic logic [CNT_W-1:0] lat_m1(input logic [4:0] op);
        int unsigned lat;
        case (op)
            5'd0, 5'd1: lat = LAT_ADD;
            5'd2:       lat = LAT_MUL;
            5'd4:       lat = LAT_SQRT;
            5'd8:       lat = LAT_DIV;
            default:    lat = LAT_MISC;
        endcase
        return CNT_W'(lat - 1);
    endfunction

    // Rounding-mode resolution; 111 selects the dynamic mode from fcsr.frm.
    always_comb begin
        rm_res     = (req_rm == 3'b111) ? sys_rm : req_rm;
        rm_illegal = (rm_res >= 3'd5);
        accept     = (state_q == StIdle) && ready_en_q && req_valid;
    end

    // Next-state and latency counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = rm_illegal ? StDone : StExec;
                    cnt_d   = lat_m1(req_op);
                end
            end
            StExec: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StDone: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (flush) begin
            state_d = StIdle;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge g_clk) begin
        if (g_rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_en_q <= 1'b1;
        end
    end

    // Operand, select, rounding-mode and result capture.
    always_ff @(posedge g_clk) begin
        if (g_rst) begin
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
            sel_q  <= '0;
            rm_q   <= '0;
            data_q <= '0;
            rd_q   <= '0;
            ill_q  <= 1'b0;
        end else if (flush) begin
            // Operands are kept; only the pending response status is dropped.
            ill_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        a_q   <= req_a;
                        b_q   <= req_b;
                        c_q   <= req_c;
                        sel_q <= req_op;
                        rd_q  <= req_rd;
                        if (rm_illegal) begin
                            data_q <= '0;
                            ill_q  <= 1'b1;
                        end else begin
                            rm_q  <= rm_res;
                            ill_q <= 1'b0;
                        end
                    end
                end
                StExec: begin
                    if (cnt_q == '0) begin
                        data_q <= fpu_res;
                        ill_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready   = (state_q == StIdle) && ready_en_q;
    assign stall       = (state_q != StIdle);
    assign fpu_enable  = (state_q == StExec);
    assign rsp_valid   = (state_q == StDone);

    assign fpu_a       = a_q;
    assign fpu_b       = b_q;
    assign fpu_c       = c_q;
    assign fpu_sel     = sel_q;
    assign fpu_rm      = rm_q;
    assign rsp_data    = data_q;
    assign rsp_rd      = rd_q;
    assign rsp_illegal = ill_q;

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Sequencer between the decode/execute stage and the multi-cycle FPU.
- Accepts one FP operation at a time over a valid/ready handshake, resolves the rounding mode, and holds operands and select stable at the FPU for the op's fixed latency.
- Captures the FPU result and presents it on a valid/ready response port.
- Drives the pipeline stall while an operation is in flight.

Parameters:
LAT_ADD, 3, FPU cycles for FADD (op 0) and FSUB (op 1)
LAT_MUL, 4, FPU cycles for FMUL (op 2)
LAT_SQRT, 12, FPU cycles for FSQRT (op 4)
LAT_DIV, 12, FPU cycles for FDIV (op 8)
LAT_MISC, 1, FPU cycles for any other op code; must be >= 1

Ports:
g_clk  in  1  single system clock
g_rst  in  1  synchronous reset, active-high
flush  in  1  synchronous abort of any op in flight
req_valid  in  1  operation request
req_ready  out  1  controller can accept
req_op  in  5  FPU select code
req_rm  in  3  instruction rounding mode; 111 = dynamic
req_a, req_b, req_c  in  32 each  operands
req_rd  in  5  destination register tag
sys_rm  in  3  fcsr.frm
fpu_a, fpu_b, fpu_c  out  32 each  operands to FPU
fpu_sel  out  5  select to FPU
fpu_rm  out  3  resolved rounding mode to FPU
fpu_enable  out  1  FPU enable
fpu_res  in  32  FPU result
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_data  out  32  result
rsp_rd  out  5  tag of result
rsp_illegal  out  1  op rejected for illegal rounding mode
stall  out  1  pipeline stall

Behaviour:
- Clock and reset: one clock, g_clk. Reset is synchronous and active-high on g_rst.
- Reset (g_rst=1 at an edge): state IDLE; all outputs and registers 0; req_ready=1 after the first non-reset edge (combinational from IDLE).
- Priority: g_rst > flush > normal operation.
- States: IDLE, EXEC, DONE.
- req_ready = (state==IDLE). stall = (state!=IDLE). fpu_enable = (state==EXEC).
- Accept: occurs on a g_clk edge with state IDLE and req_valid=1. At that edge:
  - Register req_a/b/c into fpu_a/b/c, req_op into fpu_sel, req_rd into rsp_rd.
  - Resolve rm: req_rm if req_rm != 111, else the sys_rm sampled at this edge.
- Illegal rm: resolved rm in {101, 110, 111}. The op goes directly to DONE with rsp_illegal=1 and rsp_data=0. The FPU is never enabled.
- Legal rm: fpu_rm = resolved rm; state goes to EXEC; counter = LAT(op) - 1.
  - Counter width is clog2 of the maximum latency.
- EXEC:
  - If counter==0: rsp_data <= fpu_res, rsp_illegal <= 0, state goes to DONE.
  - Otherwise counter decrements.
  - EXEC therefore lasts exactly LAT(op) cycles.
  - fpu_a/b/c, fpu_sel and fpu_rm stay constant for all of EXEC and DONE.
- Latency: for an accept at edge t, rsp_valid is first high in the cycle after edge t+LAT(op). For illegal rm, rsp_valid is high the cycle after edge t.
- DONE:
  - rsp_valid=1; rsp_data, rsp_rd and rsp_illegal are stable until the handshake.
  - rsp_valid && rsp_ready at an edge sends the state to IDLE.
  - No new request is accepted in the same edge; back-to-back ops are spaced by at least one IDLE cycle.
- sys_rm changes after the accept edge do not affect an op in flight.
- flush at an edge in any state: state goes to IDLE. rsp_valid, fpu_enable and rsp_illegal drop the next cycle. Any pending result is discarded. Operand registers keep their values.
- req_valid while not in IDLE is ignored; the requester must hold it.
- The response port is never dropped unacknowledged except by flush or reset.

Test Plan:
- FADD, rm 000: op 0, a=0x40000000, b=0x3FC00000, req_rm=000 (FPU behavioural stub returns 0x40600000).
  -> fpu_enable high exactly 3 cycles; rsp_valid 4 cycles after accept; rsp_data=0x40600000; stall high from the accept+1 cycle until the DONE handshake.
- Dynamic rm: req_rm=111, sys_rm=010 at accept; sys_rm changed to 000 the next cycle; op 2, a=0x408CCCCD, b=0x400CCCCD.
  -> fpu_rm=010 throughout EXEC; rsp_valid after 4 EXEC cycles.
- Illegal rm: req_rm=111 with sys_rm=101, then req_rm=110.
  -> each gives rsp_valid the cycle after accept, rsp_illegal=1, rsp_data=0; fpu_enable never asserts.
- Backpressure: FDIV op 8, rsp_ready held 0 for 5 cycles after rsp_valid.
  -> rsp_valid/rsp_data/rsp_rd stable; req_ready=0; a second req_valid is not accepted until one cycle after the handshake.
- Flush and reset: flush in EXEC cycle 5 of op 4 -> IDLE next cycle, no rsp_valid. Repeat with g_rst=1 in EXEC -> all outputs 0 next cycle; a new FSUB (a=0x40000000, b=0x40500000) completes normally.
- Unknown op 9: -> EXEC exactly 1 cycle (LAT_MISC); rsp_data = fpu_res sampled in that cycle.
